// File: rtl/noc_pkg.sv
// Shared NoC definitions for the tree leaves and merge nodes.
//   flit_t      : one flit, addr in the top 4 bits, payload below
//   src_flit_t  : flit tagged with the merge-node input it arrived on
package noc_pkg;

    localparam int FLIT_W   = 9;
    localparam int ADDR_W   = 4;
    localparam int ADDR_MSB = FLIT_W - 1;
    localparam int ADDR_LSB = FLIT_W - ADDR_W;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic  src;
        flit_t flit;
    } src_flit_t;

endpackage

// File: rtl/merge2_fifo.sv
// Two-entry FIFO of source-tagged flits used as the merge node output queue.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties and clears storage)
//   push        : write push_data (ignored when full)
//   push_data   : tagged flit to store
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry, all-zero after reset until first write
//   full, empty : occupancy flags
module merge2_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  src_flit_t push_data,
    input  logic      pop,
    output src_flit_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    src_flit_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Storage is cleared on reset so the output reads zero until the first flit lands.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == IDX)) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/merge2_arb_node.sv
// Two-input round-robin merge node for the return/up tree.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   in0_* / in1_*           : upstream ready/valid flit channels
//   out_valid/ready/data    : downstream channel, data is the queue head
//   out_src                 : which input the head flit came from
//   cnt0, cnt1              : saturating counts of flits accepted per input
module merge2_arb_node
    import noc_pkg::*;
#(
    parameter int FLIT_W = 9,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [FLIT_W-1:0] in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [FLIT_W-1:0] in1_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_src,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             last_grant_reg;
    logic [CNT_W-1:0] cnt0_reg;
    logic [CNT_W-1:0] cnt1_reg;

    logic      grant;
    logic      can_accept;
    logic      accept0;
    logic      accept1;
    logic      q_full;
    logic      q_empty;
    src_flit_t push_flit;
    src_flit_t head_flit;

    // Lone requester wins outright; on contention the input not served last time wins.
    assign grant = (in0_valid & in1_valid) ? ~last_grant_reg : in1_valid;

    // Readiness looks only at current occupancy, never at out_ready, so a full
    // queue refuses even when it is being drained this cycle.
    assign can_accept = ~q_full & ~reset;
    assign in0_ready  = ~grant & can_accept;
    assign in1_ready  =  grant & can_accept;
    assign accept0    = in0_valid & in0_ready;
    assign accept1    = in1_valid & in1_ready;

    always_comb begin
        push_flit      = '0;
        push_flit.src  = accept1;
        push_flit.flit = accept1 ? in1_data : in0_data;
    end

    merge2_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept0 | accept1),
        .push_data (push_flit),
        .pop       (out_ready),
        .head      (head_flit),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign out_valid = ~q_empty;
    assign out_data  = head_flit.flit;
    assign out_src   = head_flit.src;
    assign cnt0      = cnt0_reg;
    assign cnt1      = cnt1_reg;

    // last_grant starts at 1 so in0 wins the first contention after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
            cnt0_reg       <= '0;
            cnt1_reg       <= '0;
        end else begin
            if (accept0 | accept1) last_grant_reg <= accept1;
            if (accept0 && (cnt0_reg != CNT_MAX)) cnt0_reg <= cnt0_reg + 1'b1;
            if (accept1 && (cnt1_reg != CNT_MAX)) cnt1_reg <= cnt1_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_merge2_arb_node.sv
module tb_merge2_arb_node;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
    logic [8:0] in0_data = '0, in1_data = '0;
    logic       in0_ready, in1_ready, out_valid, out_src;
    logic [8:0] out_data;
    logic [3:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    // Reference state: a plain queue of {src, flit} plus round-robin memory and counters.
    logic [9:0] q[$];
    logic       m_lg = 1'b1;
    int         m_c0 = 0, m_c1 = 0;
    int         w0 = 0, w1 = 0;
    logic       m_fresh = 1'b0;
    logic       m_hold = 1'b0;
    logic [8:0] m_hold_data = '0;

    merge2_arb_node #(.FLIT_W(9), .DEPTH(2), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, commit at posedge.
    task automatic step(input logic r, input logic v0, input logic [8:0] d0,
                        input logic v1, input logic [8:0] d1, input logic ordy);
        logic g, er0, er1, a0, a1, pop;
        @(negedge clk);
        reset = r; in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1; out_ready = ordy;
        #1;
        g   = (v0 && v1) ? ~m_lg : v1;
        er0 = !r && (q.size() < 2) && !g;
        er1 = !r && (q.size() < 2) && g;
        chk("in0_ready", int'(in0_ready), int'(er0));
        chk("in1_ready", int'(in1_ready), int'(er1));
        chk("out_valid", int'(out_valid), int'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", int'(out_data), int'(q[0][8:0]));
            chk("out_src", int'(out_src), int'(q[0][9]));
        end else if (m_fresh) begin
            chk("reset_out_data", int'(out_data), 0);
            chk("reset_out_src", int'(out_src), 0);
        end
        if (m_hold) chk("stable_head", int'(out_data), int'(m_hold_data));
        chk("cnt0", int'(cnt0), m_c0);
        chk("cnt1", int'(cnt1), m_c1);
        a0  = v0 && er0;
        a1  = v1 && er1;
        pop = (q.size() != 0) && ordy;
        m_hold = !r && !pop && (q.size() != 0);
        if (q.size() != 0) m_hold_data = q[0][8:0];
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_lg = 1'b1; m_c0 = 0; m_c1 = 0; w0 = 0; w1 = 0;
            m_fresh = 1'b1; m_hold = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (a0) q.push_back({1'b0, d0});
            if (a1) q.push_back({1'b1, d1});
            if (a0 || a1) begin
                m_lg = a1;
                m_fresh = 1'b0;
            end
            if (a0 && m_c0 < 15) m_c0++;
            if (a1 && m_c1 < 15) m_c1++;
            if (a0) w0 = 0; else if (v0 && a1) w0++; else if (!v0) w0 = 0;
            if (a1) w1 = 0; else if (v1 && a0) w1++; else if (!v1) w1 = 0;
            chk("max_wait0", int'(w0 <= 1), 1);
            chk("max_wait1", int'(w1 <= 1), 1);
        end
    endtask

    initial begin
        // Test 1: single flit on in0, latency 1
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, 9'h1A5, 0, 0, 1);
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_out_data", int'(out_data), 'h1A5);
        chk("t1_out_src", int'(out_src), 0);
        chk("t1_cnt0", int'(cnt0), 1);
        chk("t1_cnt1", int'(cnt1), 0);

        // Test 2: both valid every cycle, sources alternate starting with in0
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 9'h011, 1, 9'h122, 1);
            chk("t2_out_src", int'(out_src), i % 2);
            chk("t2_out_data", int'(out_data), (i % 2) ? 'h122 : 'h011);
        end
        chk("t2_cnt0", int'(cnt0), 4);
        chk("t2_cnt1", int'(cnt1), 4);

        // Test 3: backpressure fills the queue, then drains in order
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 9'h0F0, 0);
        step(0, 0, 0, 1, 9'h0F1, 0);
        chk("t3_in1_ready_full", int'(in1_ready), 0);
        chk("t3_head0", int'(out_data), 'h0F0);
        step(0, 0, 0, 1, 9'h0F2, 0);
        chk("t3_head_held", int'(out_data), 'h0F0);
        chk("t3_cnt1_2", int'(cnt1), 2);
        step(0, 0, 0, 1, 9'h0F2, 1);
        chk("t3_head1", int'(out_data), 'h0F1);
        step(0, 0, 0, 1, 9'h0F2, 1);
        chk("t3_head2", int'(out_data), 'h0F2);
        chk("t3_src", int'(out_src), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t3_drained", int'(out_valid), 0);
        chk("t3_cnt1_3", int'(cnt1), 3);

        // Test 4: reset with two flits queued
        step(0, 1, 9'h0AA, 0, 0, 0);
        step(0, 1, 9'h0AB, 0, 0, 0);
        step(1, 1, 9'h0AC, 0, 0, 0);
        chk("t4_out_valid", int'(out_valid), 0);
        chk("t4_cnt0", int'(cnt0), 0);
        chk("t4_cnt1", int'(cnt1), 0);
        step(0, 1, 9'h055, 0, 0, 0);
        chk("t4_latency1", int'(out_valid), 1);
        chk("t4_data", int'(out_data), 'h055);

        // Test 5: counter saturation at 15 for a 4-bit counter
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 9'(i), 0, 0, 1);
        chk("t5_cnt0_sat", int'(cnt0), 15);

        // Test 6: random traffic, occasional reset, bursty backpressure
        for (int i = 0; i < 10000; i++) begin
            logic r, v0, v1, ordy;
            r    = ($urandom_range(0, 499) == 0);
            v0   = ($urandom_range(0, 3) != 0);
            v1   = ($urandom_range(0, 2) != 0);
            ordy = ((i / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0);
            step(r, v0, 9'($urandom), v1, 9'($urandom), ordy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
